// File: rtl/task5_spi_slave.sv
// Serial command slave: 2-bit opcode followed by a 1- or 32-bit payload, MSB first.
// Opcodes: 00 write DATA_O, 01 flag/clear accumulator, 10 add, 11 subtract.
// The accumulator snapshot is shifted out on MISO during 32-bit payloads.
module task5_spi_slave #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             SCLK,
    input  logic             RST,
    input  logic             MOSI,
    input  logic             SS,
    output logic             MISO,
    output logic [WIDTH-1:0] DATA_O,
    output logic [WIDTH-1:0] ACC_O,
    output logic             FLAG_O
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [2:0] {StCmd1, StCmd0, StPay1, StPay32, StDone} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] tx_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] word;

    // Word as it stands including the bit arriving on this edge.
    assign word = {rx_q[WIDTH-2:0], MOSI};

    // Frame FSM with registered data, accumulator and flag outputs.
    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q <= StCmd1;
            op_q    <= 2'b00;
            rx_q    <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            DATA_O  <= '0;
            ACC_O   <= '0;
            FLAG_O  <= 1'b0;
        end else if (!SS) begin
            // Deselect aborts any partial frame without touching committed state.
            state_q <= StCmd1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StCmd1: begin
                    op_q[1] <= MOSI;
                    state_q <= StCmd0;
                end
                StCmd0: begin
                    op_q[0] <= MOSI;
                    rx_q    <= '0;
                    tx_q    <= ACC_O;
                    cnt_q   <= '0;
                    state_q <= ({op_q[1], MOSI} == 2'b01) ? StPay1 : StPay32;
                end
                StPay1: begin
                    FLAG_O <= MOSI;
                    if (MOSI) begin
                        ACC_O <= '0;
                    end
                    state_q <= StDone;
                end
                StPay32: begin
                    rx_q  <= word;
                    tx_q  <= {tx_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        case (op_q)
                            2'b00:   DATA_O <= word;
                            2'b10:   ACC_O  <= ACC_O + word;
                            2'b11:   ACC_O  <= ACC_O - word;
                            default: ;
                        endcase
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StDone;
                default: state_q <= StCmd1;
            endcase
        end
    end

    // Readout is only driven while a 32-bit payload is in flight.
    assign MISO = (SS && (state_q == StPay32)) ? tx_q[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_task5_spi_slave.sv
// Directed bench for task5_spi_slave: inputs change on SCLK negedge, outputs
// are checked on negedge, well away from the sampling posedge.
module tb_task5_spi_slave;

    logic        SCLK;
    logic        RST;
    logic        MOSI;
    logic        SS;
    logic        MISO;
    logic [31:0] DATA_O;
    logic [31:0] ACC_O;
    logic        FLAG_O;

    int          tests;
    int          fails;
    logic [31:0] rd;

    task5_spi_slave #(.WIDTH(32)) dut (
        .SCLK  (SCLK),
        .RST   (RST),
        .MOSI  (MOSI),
        .SS    (SS),
        .MISO  (MISO),
        .DATA_O(DATA_O),
        .ACC_O (ACC_O),
        .FLAG_O(FLAG_O)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one bit with SS high; record MISO as presented before the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge SCLK);
        SS   = 1'b1;
        MOSI = b;
        #1;
        rd = {rd[30:0], MISO};
    endtask

    task automatic send_op(input logic [1:0] op);
        send_bit(op[1]);
        send_bit(op[0]);
        rd = '0;
    endtask

    task automatic send_payload(input logic [31:0] data, input int n);
        for (int k = 0; k < n; k++) send_bit(data[31-k]);
    endtask

    // One negedge with SS low, so one deselected posedge follows.
    task automatic end_frame();
        @(negedge SCLK);
        SS   = 1'b0;
        MOSI = 1'b0;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rd    = '0;
        RST   = 1'b1;
        SS    = 1'b0;
        MOSI  = 1'b0;

        // Reset held for two edges
        repeat (2) @(negedge SCLK);
        RST = 1'b0;
        #1;
        chk("reset_data", DATA_O, 32'h0);
        chk("reset_acc", ACC_O, 32'h0);
        chk("reset_flag", {31'h0, FLAG_O}, 32'h0);
        chk("reset_miso", {31'h0, MISO}, 32'h0);

        // Add 0xF to zero accumulator; readout shows old value 0
        send_op(2'b10);
        send_payload(32'h0000000F, 32);
        end_frame();
        chk("add_acc", ACC_O, 32'h0000000F);
        chk("add_miso", rd, 32'h0);

        // Subtract 3; readout is the 0xF snapshot
        send_op(2'b11);
        send_payload(32'h00000003, 32);
        chk("sub_miso", rd, 32'h0000000F);
        end_frame();
        chk("sub_acc", ACC_O, 32'h0000000C);
        chk("idle_miso", {31'h0, MISO}, 32'h0);

        // Op 01 with payload 0: flag low, accumulator kept
        send_op(2'b01);
        send_payload(32'h0, 1);
        end_frame();
        chk("flag0_flag", {31'h0, FLAG_O}, 32'h0);
        chk("flag0_acc", ACC_O, 32'h0000000C);

        // Clear, then extra bits that must be ignored until SS falls
        send_op(2'b01);
        send_payload(32'h80000000, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_payload(32'hFFFFFFFF, 32);
        chk("clear_miso", {31'h0, MISO}, 32'h0);
        end_frame();
        chk("clear_flag", {31'h0, FLAG_O}, 32'h1);
        chk("clear_acc", ACC_O, 32'h0);

        // Back-to-back writes
        send_op(2'b00);
        send_payload(32'h00000003, 32);
        end_frame();
        chk("write3", DATA_O, 32'h00000003);
        send_op(2'b00);
        send_payload(32'h0000000A, 32);
        end_frame();
        chk("writeA", DATA_O, 32'h0000000A);

        // Subtract wrap below zero
        send_op(2'b11);
        send_payload(32'h00000001, 32);
        end_frame();
        chk("wrap_acc", ACC_O, 32'hFFFFFFFF);

        // Aborted write after 10 payload bits
        send_op(2'b00);
        send_payload(32'h12345678, 10);
        end_frame();
        chk("abort_data", DATA_O, 32'h0000000A);
        chk("abort_acc", ACC_O, 32'hFFFFFFFF);

        // Next frame decodes normally; add wraps to 4, readout shows FFFFFFFF
        send_op(2'b10);
        send_payload(32'h00000005, 32);
        chk("wrapadd_miso", rd, 32'hFFFFFFFF);
        end_frame();
        chk("wrapadd_acc", ACC_O, 32'h00000004);

        // Reset in the middle of a 32-bit payload
        send_op(2'b10);
        send_payload(32'h0000FFFF, 5);
        @(negedge SCLK);
        RST = 1'b1;
        @(negedge SCLK);
        #1;
        chk("midrst_data", DATA_O, 32'h0);
        chk("midrst_acc", ACC_O, 32'h0);
        chk("midrst_flag", {31'h0, FLAG_O}, 32'h0);
        chk("midrst_miso", {31'h0, MISO}, 32'h0);
        RST = 1'b0;
        SS  = 1'b0;

        // Fresh frame after reset starts from CMD1
        end_frame();
        send_op(2'b10);
        send_payload(32'h00000007, 32);
        end_frame();
        chk("postrst_acc", ACC_O, 32'h00000007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
